// File: rtl/mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_sequencer
// Purpose  : Steps a select through the legal codes 0..NUM_CODES-1, holding
//            each code for a programmable dwell, with start/stop control.
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_sequencer #(
    parameter int SEL_W     = 2,
    parameter int DWELL_W   = 8,
    parameter int NUM_CODES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               wrap
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] C_LAST_CODE = SEL_W'(NUM_CODES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DWELL_W-1:0]   r_cnt;
    logic [DWELL_W-1:0]   w_cnt_nxt;
    logic [DWELL_W-1:0]   r_dwell;
    logic [DWELL_W-1:0]   w_dwell_nxt;
    logic [DWELL_W-1:0]   w_dwell_eff;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_wrap;
    logic                 w_wrap_nxt;

    // A zero dwell is treated as one cycle per code
    assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dwell <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dwell <= w_dwell_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dwell_nxt = r_dwell;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_wrap_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = RUN;
                    w_sel_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_dwell_nxt = w_dwell_eff;
                    w_cnt_nxt   = w_dwell_eff - DWELL_W'(1);
                end
            end
            RUN: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - DWELL_W'(1);
                end else begin
                    w_cnt_nxt = r_dwell - DWELL_W'(1);
                    if (r_sel == C_LAST_CODE) begin
                        w_sel_nxt  = '0;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_sel_nxt = r_sel + SEL_W'(1);
                    end
                end
                if (stop) begin
                    w_state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                // Let the current code finish its dwell, then hold it
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - DWELL_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign sel       = r_sel;
    assign sel_valid = r_valid;
    assign busy      = r_busy;
    assign wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sel_sequencer
// Purpose  : Scoreboard bench: directed runs push expected sel/wrap samples,
//            a negedge monitor pops and compares while sel_valid is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sel_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic [7:0] dwell;
    logic [1:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       wrap;

    int n_vec;
    int n_err;

    typedef struct packed {
        logic [1:0] sel;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];

    mux_sel_sequencer #(
        .SEL_W    (2),
        .DWELL_W  (8),
        .NUM_CODES(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .dwell    (dwell),
        .sel      (sel),
        .sel_valid(sel_valid),
        .busy     (busy),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Expected visible samples of a run with effective dwell d
    task automatic push_run(input int d, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.sel  = 2'((k / d) % 3);
            e.wrap = (k != 0) && (k % d == 0) && (e.sel == 2'd0);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_run(input logic [7:0] d);
        dwell = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Asynchronous abort, checked before any clock edge can occur
    task automatic abort_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_rst_sel"},   int'(sel), 0);
        check({tag, "_rst_busy"},  int'(busy), 0);
        check({tag, "_rst_valid"}, int'(sel_valid), 0);
        check({tag, "_rst_wrap"},  int'(wrap), 0);
        reset = 1'b1;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("sel_legal", int'(sel < 2'd3), 1);
            if (sel_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sel",  int'(sel),  int'(e.sel));
                    check("wrap", int'(wrap), int'(e.wrap));
                end
            end else begin
                check("wrap_idle", int'(wrap), 0);
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        start = 1'b0;
        stop  = 1'b0;
        dwell = 8'd0;

        // 1: power-on reset, no clock edge involved
        reset = 1'b0;
        #2;
        check("por_sel",   int'(sel), 0);
        check("por_valid", int'(sel_valid), 0);
        check("por_busy",  int'(busy), 0);
        check("por_wrap",  int'(wrap), 0);
        #1 reset = 1'b1;
        #1;
        check("rel_busy", int'(busy), 0);
        check("rel_sel",  int'(sel), 0);
        repeat (2) @(posedge clk);
        #1;

        // 2: dwell=4, 0x4,1x4,2x4 then 0 with wrap on the 13th sample
        push_run(4, 14);
        start_run(8'd4);
        repeat (13) @(posedge clk);
        @(negedge clk);
        #1 abort_reset("t2");
        check("t2_drained", exp_q.size(), 0);

        // 3: dwell=0 behaves as dwell=1: 0,1,2,0,1
        push_run(1, 5);
        start_run(8'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1 abort_reset("t3");
        check("t3_drained", exp_q.size(), 0);

        // 4: dwell=5, stop in 2nd cycle of code 1
        push_run(5, 10);
        start_run(8'd5);
        repeat (6) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        begin
            int waited;
            waited = 0;
            while (busy === 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("t4_stop_timeout", int'(busy === 1'b1), 0);
            check("t4_stop_cycles", waited, 4);
        end
        check("t4_sel_hold",  int'(sel), 1);
        check("t4_valid_off", int'(sel_valid), 0);
        check("t4_drained", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("t4_sel_still", int'(sel), 1);

        // 5: dwell=3, abort once sel=2, then restart from 0
        @(posedge clk);
        #1;
        push_run(3, 7);
        start_run(8'd3);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1 abort_reset("t5");
        check("t5_drained", exp_q.size(), 0);
        push_run(3, 4);
        start_run(8'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 abort_reset("t5b");
        check("t5b_drained", exp_q.size(), 0);

        // 6: dwell change and start pulse mid-run are ignored
        push_run(2, 10);
        start_run(8'd2);
        @(posedge clk);
        #1;
        dwell = 8'd6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        #1 abort_reset("t6");
        check("t6_drained", exp_q.size(), 0);

        // start together with stop in IDLE: stop wins
        @(posedge clk);
        #1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        check("t6_ss_busy",  int'(busy), 0);
        check("t6_ss_valid", int'(sel_valid), 0);
        repeat (2) @(negedge clk);
        check("t6_ss_idle", int'(busy), 0);

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
